// File: rtl/info_string_bank_if.sv
// info_string_bank_if: CPU register bus bundle for info_string_bank.
//   address_i  bus address (master -> slave)
//   data_i     write data  (master -> slave)
//   rd_wr_i    1 = write strobe, 0 = read (master -> slave)
//   data_o     registered read data (slave -> master)
interface info_string_bank_if #(
  parameter int unsigned address_width = 15,
  parameter int unsigned data_width    = 16
);
  logic [address_width-1:0] address_i;
  logic [data_width-1:0]    data_i;
  logic                     rd_wr_i;
  logic [data_width-1:0]    data_o;

  modport master (output address_i, output data_i, output rd_wr_i, input data_o);
  modport slave  (input address_i, input data_i, input rd_wr_i, output data_o);
endinterface

// File: rtl/info_string_bank.sv
// info_string_bank: read-only bank of ASCII info strings on the register bus.
// Strings are read either through SELECT/PTR/DATA with an auto-advancing
// pointer, or through a directly addressed window onto the selected string.
//   clk_i    system clock
//   reset_i  synchronous, active-high reset
//   bus      info_string_bank_if.slave (address_i, data_i, rd_wr_i, data_o)
`ifndef VERSION_STRING
`define VERSION_STRING "info_string_bank default version string 0001"
`endif

module info_string_bank #(
  parameter int unsigned BaseAddress     = 0,
  parameter int unsigned NumStrings      = 4,
  parameter int unsigned MaxChars        = 44,
  parameter int unsigned address_width   = 15,
  parameter int unsigned data_width      = 16,
  parameter int unsigned Address_Wording = 1,
  parameter int unsigned CharsPerWord    = data_width / 8,
  parameter logic [NumStrings*MaxChars*8-1:0] Strings =
    ((NumStrings*MaxChars*8)'(`VERSION_STRING)) << ((NumStrings-1)*MaxChars*8),
  parameter logic [NumStrings*8-1:0] Lengths = {NumStrings{8'(MaxChars)}}
) (
  input logic                clk_i,
  input logic                reset_i,
  info_string_bank_if.slave  bus
);

  localparam int unsigned DW          = data_width;
  localparam int unsigned AW          = address_width;
  localparam int unsigned WindowWords = (MaxChars + CharsPerWord - 1) / CharsPerWord;
  localparam int unsigned SIW         = $clog2(NumStrings*MaxChars*8);
  localparam int unsigned LIW         = $clog2(NumStrings*8);

  localparam logic [AW-1:0] BaseA    = AW'(BaseAddress);
  localparam logic [AW-1:0] WordA    = AW'(Address_Wording);
  localparam logic [AW-1:0] W_SELECT = AW'(0);
  localparam logic [AW-1:0] W_PTR    = AW'(1);
  localparam logic [AW-1:0] W_DATA   = AW'(2);
  localparam logic [AW-1:0] W_STATUS = AW'(3);
  localparam logic [AW-1:0] W_WIN    = AW'(4);
  localparam logic [AW-1:0] W_WEND   = AW'(4 + WindowWords);

  logic [7:0]    select_q, select_d;
  logic [7:0]    ptr_q, ptr_d;
  logic          wrap_q, wrap_d;
  logic [DW-1:0] data_o_q, data_o_d;

  logic          in_map;
  logic [AW-1:0] offset;
  logic [AW-1:0] w;
  logic          sel_valid;
  logic [7:0]    len;
  logic [DW-1:0] status;
  logic [8:0]    ptr_adv;
  int unsigned   win_k;

  // Out-of-range positions (past LEN or past the slot) read as NUL.
  function automatic logic [7:0] char_at(input int unsigned sel, input int unsigned pos,
                                         input int unsigned slen);
    logic [SIW-1:0] idx;
    if (sel >= NumStrings || pos >= slen || pos >= MaxChars) return 8'h00;
    idx = SIW'(((NumStrings - 1 - sel) * MaxChars + (MaxChars - 1 - pos)) * 8);
    return Strings[idx +: 8];
  endfunction

  // First char lands in the MSB byte; a short tail is zero-padded on the right.
  function automatic logic [DW-1:0] word_at(input int unsigned sel, input int unsigned start,
                                            input int unsigned slen);
    logic [DW-1:0] wd;
    wd = '0;
    for (int i = 0; i < int'(CharsPerWord); i++) begin
      wd[(int'(CharsPerWord) - 1 - i) * 8 +: 8] = char_at(sel, start + 32'(i), slen);
    end
    return wd;
  endfunction

  always_comb begin
    in_map    = (bus.address_i >= BaseA);
    offset    = bus.address_i - BaseA;
    w         = offset / WordA;
    sel_valid = (32'(select_q) < NumStrings);
    len       = 8'd0;
    if (sel_valid) len = Lengths[LIW'((NumStrings - 1 - 32'(select_q)) * 8) +: 8];

    status      = '0;
    status[0]   = wrap_q;
    status[1]   = !sel_valid;
    status[15:8] = len;

    ptr_adv = {1'b0, ptr_q} + 9'(CharsPerWord);
    win_k   = 32'(w - W_WIN) * CharsPerWord;

    select_d = select_q;
    ptr_d    = ptr_q;
    wrap_d   = wrap_q;
    data_o_d = '0;

    if (bus.rd_wr_i) begin
      // Write cycles always return 0 on the following cycle.
      if (in_map) begin
        if (w == W_SELECT) begin
          select_d = bus.data_i[7:0];
          ptr_d    = 8'd0;
          wrap_d   = 1'b0;
        end else if (w == W_PTR) begin
          ptr_d = (bus.data_i >= DW'(len)) ? 8'd0 : bus.data_i[7:0];
        end else if (w == W_DATA) begin
          if (ptr_adv >= {1'b0, len}) begin
            ptr_d  = 8'd0;
            wrap_d = 1'b1;
          end else begin
            ptr_d = ptr_adv[7:0];
          end
        end
      end
    end else if (in_map) begin
      if (w == W_STATUS) begin
        data_o_d = status;
      end else if (sel_valid) begin
        if (w == W_SELECT) begin
          data_o_d = DW'(select_q);
        end else if (w == W_PTR) begin
          data_o_d = DW'(ptr_q);
        end else if (w == W_DATA) begin
          data_o_d = word_at(32'(select_q), 32'(ptr_q), 32'(len));
        end else if (w >= W_WIN && w < W_WEND) begin
          data_o_d = word_at(32'(select_q), win_k, 32'(len));
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      select_q <= 8'd0;
      ptr_q    <= 8'd0;
      wrap_q   <= 1'b0;
      data_o_q <= '0;
    end else begin
      select_q <= select_d;
      ptr_q    <= ptr_d;
      wrap_q   <= wrap_d;
      data_o_q <= data_o_d;
    end
  end

  assign bus.data_o = data_o_q;

endmodule

// File: tb/tb_info_string_bank.sv
module tb_info_string_bank;
  localparam int BASE = 16;
  localparam logic [351:0] S0 = "VER 1.04.2 2024-06-01 g3f9a1c2 BOARD-7 ACME.";
  localparam logic [351:0] S1 = {"ABCDE", 312'h0};
  localparam logic [351:0] S2 = {44{8'h5A}};
  localparam logic [351:0] S3 = "abcdefghijklmnopqrstuvwxyz0123456789ABCDEFGH";

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  info_string_bank_if #(.address_width(15), .data_width(16)) bus ();

  info_string_bank #(
    .BaseAddress(BASE),
    .Strings({S0, S1, S2, S3}),
    .Lengths({8'd44, 8'd5, 8'd0, 8'd44})
  ) dut (
    .clk_i(clk),
    .reset_i(rst),
    .bus(bus.slave)
  );

  logic [351:0] bank [4];
  int           lens [4];
  logic [15:0]  sbq [$];
  string        tagq [$];
  int           errors = 0;
  int           checks = 0;

  function automatic logic [7:0] exp_char(input int s, input int p);
    if (p >= lens[s] || p >= 44) return 8'h00;
    return bank[s][(43 - p) * 8 +: 8];
  endfunction

  function automatic logic [15:0] exp_word(input int s, input int p);
    return {exp_char(s, p), exp_char(s, p + 1)};
  endfunction

  task automatic cycle();
    logic [15:0] exp;
    string t;
    @(posedge clk);
    #1;
    exp = sbq.pop_front();
    t = tagq.pop_front();
    checks++;
    assert (bus.data_o === exp)
      else begin
        errors++;
        $error("FAIL %s: data_o=%h expected %h", t, bus.data_o, exp);
      end
  endtask

  task automatic rd_raw(input int addr, input logic [15:0] exp, input string tag);
    bus.address_i = 15'(addr);
    bus.rd_wr_i   = 1'b0;
    bus.data_i    = 16'h0;
    sbq.push_back(exp);
    tagq.push_back(tag);
    cycle();
  endtask

  task automatic rd(input int w, input logic [15:0] exp, input string tag);
    rd_raw(BASE + w, exp, tag);
  endtask

  task automatic wr(input int w, input logic [15:0] d, input string tag);
    bus.address_i = 15'(BASE + w);
    bus.rd_wr_i   = 1'b1;
    bus.data_i    = d;
    sbq.push_back(16'h0);
    tagq.push_back(tag);
    cycle();
  endtask

  initial begin
    bank[0] = S0; bank[1] = S1; bank[2] = S2; bank[3] = S3;
    lens[0] = 44; lens[1] = 5;  lens[2] = 0;  lens[3] = 44;
    bus.address_i = '0;
    bus.data_i    = '0;
    bus.rd_wr_i   = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rd(2, 16'h0000, "reset_data_o");
    rst = 1'b0;

    // Reset state
    rd(0, 16'h0000, "t1_select");
    rd(1, 16'h0000, "t1_ptr");
    rd(2, 16'h5645, "t1_data");
    rd(3, 16'h2C00, "t1_status");

    // Stream the whole of slot 0
    wr(0, 16'h0000, "t2_sel_wr");
    for (int k = 0; k < 22; k++) begin
      rd(2, exp_word(0, 2 * k), $sformatf("t2_data_%0d", k));
      wr(2, 16'hFFFF, "t2_adv");
    end
    rd(1, 16'h0000, "t2_ptr_wrapped");
    rd(3, 16'h2C01, "t2_status_wrap");
    wr(2, 16'h0000, "t2_adv_again");
    rd(1, 16'h0002, "t2_ptr_after");
    rd(3, 16'h2C01, "t2_wrap_sticky");

    // Short string with zero-padded tail
    wr(0, 16'h0001, "t3_sel_wr");
    rd(2, 16'h4142, "t3_w0");
    wr(2, 16'h0000, "t3_adv0");
    rd(2, 16'h4344, "t3_w1");
    wr(2, 16'h0000, "t3_adv1");
    rd(3, 16'h0500, "t3_nowrap");
    rd(2, 16'h4500, "t3_w2");
    wr(2, 16'h0000, "t3_adv2");
    rd(3, 16'h0501, "t3_wrap");
    rd(1, 16'h0000, "t3_ptr0");
    wr(0, 16'h0001, "t3_sel_again");
    rd(3, 16'h0500, "t3_wrap_clr");

    // Pointer writes, including the LEN boundary
    wr(1, 16'h0003, "t4_ptr_wr3");
    rd(1, 16'h0003, "t4_ptr3");
    rd(2, 16'h4445, "t4_data_p3");
    wr(1, 16'h0005, "t4_ptr_wr5");
    rd(1, 16'h0000, "t4_ptr_eq_len");
    wr(1, 16'h0004, "t4_ptr_wr4");
    rd(2, 16'h4500, "t4_data_p4");
    wr(1, 16'd60, "t4_ptr_wr60");
    rd(1, 16'h0000, "t4_ptr_60");

    // Empty string
    wr(0, 16'h0002, "len0_sel");
    rd(2, 16'h0000, "len0_data");
    wr(2, 16'h0000, "len0_adv");
    rd(1, 16'h0000, "len0_ptr");
    rd(3, 16'h0001, "len0_status");
    rd(4, 16'h0000, "len0_window");

    // Invalid selection and the window
    wr(0, 16'h0004, "t5_sel_inv");
    rd(3, 16'h0002, "t5_status_inv");
    rd(2, 16'h0000, "t5_data_inv");
    rd(4, 16'h0000, "t5_win_inv");
    wr(0, 16'h0001, "t5_sel1");
    rd(4, 16'h4142, "t5_win0");
    rd(6, 16'h4500, "t5_win2");
    rd(7, 16'h0000, "t5_win3");
    wr(0, 16'h0003, "t5_sel3");
    rd(14, exp_word(3, 20), "t5_win10");
    rd(25, 16'h4748, "t5_win_last");
    rd(26, 16'h0000, "t5_past_win");

    // Reset colliding with a DATA write mid-stream
    wr(0, 16'h0000, "t6_sel0");
    wr(2, 16'h0000, "t6_adv0");
    wr(2, 16'h0000, "t6_adv1");
    wr(2, 16'h0000, "t6_adv2");
    rd(1, 16'h0006, "t6_ptr6");
    rst = 1'b1;
    bus.address_i = 15'(BASE + 2);
    bus.rd_wr_i   = 1'b1;
    bus.data_i    = 16'h0000;
    sbq.push_back(16'h0000);
    tagq.push_back("t6_reset_write");
    cycle();
    rst = 1'b0;
    rd(1, 16'h0000, "t6_ptr_reset");
    rd(3, 16'h2C00, "t6_status_reset");
    rd(2, 16'h5645, "t6_data_reset");
    rd(3, 16'h2C00, "t6_status_pre_oom");
    rd_raw(5, 16'h0000, "below_base");
    rd_raw(BASE - 1, 16'h0000, "below_base_edge");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
